// File: rtl/pac_rr_pkg.sv
// Shared types and sizing for the weighted round-robin scheduler.
package pac_rr_pkg;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned WEIGHT_W    = 3;
    localparam int unsigned IDX_W       = $clog2(NUM_REQ);
    localparam int unsigned AGE_W_DEF   = 4;
    localparam int unsigned AGE_MAX_DEF = 12;

    typedef logic [NUM_REQ-1:0]  req_vec_t;
    typedef logic [IDX_W-1:0]    idx_t;
    typedef logic [WEIGHT_W-1:0] credit_t;

    typedef struct packed {
        logic [NUM_REQ-1:0][WEIGHT_W-1:0] weight;
    } pac_cfg_t;

    typedef enum logic {IDLE, GRANT} sched_state_e;

endpackage

// File: rtl/pac_rr_pick.sv
// Round-robin picker: aged eligible requesters first, then any eligible, scanning up from ptr.
module pac_rr_pick
    import pac_rr_pkg::*;
(
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [NUM_REQ-1:0] aged_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   win_idx_o,
    output logic               win_valid_o
);

    req_vec_t               cand;
    req_vec_t               rot;
    logic [2*NUM_REQ-1:0]   dbl;
    idx_t                   off;

    always_comb begin
        cand = (|(elig_i & aged_i)) ? (elig_i & aged_i) : elig_i;
        // Rotate so that ptr sits at bit 0, then take the lowest set bit.
        dbl  = {cand, cand} >> ptr_i;
        rot  = dbl[NUM_REQ-1:0];
        off  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = idx_t'(i);
        end
        win_idx_o   = ptr_i + off;
        win_valid_o = |cand;
    end

endmodule

// File: rtl/pac_wrr_sched.sv
// Weighted round-robin scheduler: registered one-hot grant to a shared sink, credit-limited
// bursts per grant and saturating ages that force priority for starved requesters.
module pac_wrr_sched
    import pac_rr_pkg::*;
#(
    parameter int unsigned AGE_W   = AGE_W_DEF,
    parameter int unsigned AGE_MAX = AGE_MAX_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic                src_valid_i,
    input  logic                sink_ready_i,
    input  pac_cfg_t            cfg_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic                busy_o,
    output logic [WEIGHT_W-1:0] credit_o,
    output logic [NUM_REQ-1:0]  aged_o
);

    sched_state_e     state_q, state_d;
    req_vec_t         grant_q, grant_d;
    idx_t             idx_q, idx_d;
    idx_t             ptr_q, ptr_d;
    credit_t          credit_q, credit_d;
    logic [AGE_W-1:0] age_q [NUM_REQ];
    logic [AGE_W-1:0] age_d [NUM_REQ];

    req_vec_t elig, aged;
    idx_t     pick_ptr, win_idx;
    logic     win_valid, beat, release_grant, load;

    always_comb begin
        elig = '0;
        aged = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req_i[i] & (cfg_i.weight[i] != '0);
            aged[i] = (age_q[i] == AGE_W'(AGE_MAX));
        end
    end

    assign beat          = src_valid_i & sink_ready_i & (state_q == GRANT);
    assign release_grant = (beat & (credit_q == credit_t'(1))) | ~req_i[idx_q]
                         | (cfg_i.weight[idx_q] == '0);
    // On release the scan restarts just past the current holder.
    assign pick_ptr      = (state_q == GRANT) ? idx_q + idx_t'(1) : ptr_q;

    pac_rr_pick u_pick (
        .elig_i      (elig),
        .aged_i      (aged),
        .ptr_i       (pick_ptr),
        .win_idx_o   (win_idx),
        .win_valid_o (win_valid)
    );

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: load = win_valid;
            GRANT: begin
                if (release_grant) begin
                    ptr_d = pick_ptr;
                    if (win_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        idx_d    = '0;
                        credit_d = '0;
                    end
                end else if (beat) begin
                    credit_d = credit_q - credit_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d  = GRANT;
            grant_d  = req_vec_t'(1) << win_idx;
            idx_d    = win_idx;
            credit_d = cfg_i.weight[win_idx];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            age_d[i] = age_q[i];
            if (!req_i[i] || (grant_d[i] && !grant_q[i])) begin
                age_d[i] = '0;
            end else if (elig[i] && !grant_q[i] && !aged[i]) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            ptr_q    <= '0;
            credit_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = (state_q == GRANT);
    assign credit_o    = credit_q;
    assign aged_o      = aged;

endmodule
